// File: rtl/uart_rx_fifo_gen.sv
// UART receive channel: majority-vote deserialiser (5..9 data bits, optional parity,
// 1/2 stop bits) feeding a first-word-fall-through FIFO with error tags and overrun flag.
module uart_rx_fifo_gen #(
  parameter int SIZE_DATA   = 8,
  parameter int SIZE_DEPTH  = 4,
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stick,
  input  logic                  i_rx_en,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_two_stop,
  input  logic                  i_rx_data,
  input  logic                  i_rd_en,
  input  logic                  i_clr_err,
  output logic [SIZE_DATA-1:0]  o_rx_data,
  output logic                  o_rx_perr,
  output logic                  o_rx_ferr,
  output logic                  o_rx_valid,
  output logic                  o_fifo_full,
  output logic [SIZE_DEPTH:0]   o_fifo_count,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int TICK_W = $clog2(OVER_SAMPLE);
  localparam int BIT_W  = $clog2(SIZE_DATA);
  localparam int DEPTH  = 2 ** SIZE_DEPTH;
  localparam int CNT_W  = SIZE_DEPTH + 1;
  localparam int WORD_W = SIZE_DATA + 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_next;

  logic                  rx_meta, rx_sync, rx_prev;
  logic [TICK_W-1:0]     tick;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_idx;
  logic [1:0]            samp;
  logic [SIZE_DATA-1:0]  shreg;
  logic                  perr_q, ferr_q;
  logic                  mode_par_en, mode_odd, mode_two;
  logic                  wr_valid;
  logic [WORD_W-1:0]     wr_word;

  logic                  falling, in_window, vote_tick, bit_end, vote, par_exp;
  logic                  start_frame, end_frame;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx_data;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign falling   = rx_prev & ~rx_sync;
  assign in_window = (tick >= TICK_W'(MID_SAMPLE - 1)) && (tick <= TICK_W'(MID_SAMPLE + 1));
  assign vote_tick = (tick == TICK_W'(MID_SAMPLE + 1));
  assign bit_end   = (tick == TICK_W'(OVER_SAMPLE - 1));
  // The third sample of the vote is the live line at tick MID_SAMPLE+1.
  assign vote      = (samp[1] & samp[0]) | (samp[1] & rx_sync) | (samp[0] & rx_sync);
  assign par_exp   = (^shreg) ^ mode_odd;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_rx_en && falling) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (i_stick && vote_tick && vote)  state_next = IDLE;
        else if (i_stick && bit_end)       state_next = DATA;
      end
      DATA: begin
        if (i_stick && bit_end && bit_cnt == BIT_W'(SIZE_DATA - 1))
          state_next = mode_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (i_stick && bit_end) state_next = STOP;
      end
      STOP: begin
        if (i_stick && vote_tick && (!mode_two || stop_idx)) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Disabling the receiver abandons any partial frame.
    if (state != IDLE && !i_rx_en) begin
      state_next = IDLE;
      end_frame  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick        <= '0;
      bit_cnt     <= '0;
      stop_idx    <= 1'b0;
      samp        <= 2'b11;
      shreg       <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      mode_par_en <= 1'b0;
      mode_odd    <= 1'b0;
      mode_two    <= 1'b0;
      wr_valid    <= 1'b0;
      wr_word     <= '0;
    end else begin
      wr_valid <= end_frame;
      if (end_frame) wr_word <= {ferr_q | ~vote, perr_q, shreg};

      if (start_frame) begin
        tick        <= '0;
        bit_cnt     <= '0;
        stop_idx    <= 1'b0;
        perr_q      <= 1'b0;
        ferr_q      <= 1'b0;
        mode_par_en <= i_parity_en;
        mode_odd    <= i_parity_odd;
        mode_two    <= i_two_stop;
      end else if (state != IDLE && i_stick) begin
        tick <= bit_end ? '0 : tick + TICK_W'(1);
        if (in_window) samp <= {samp[0], rx_sync};
        if (vote_tick) begin
          case (state)
            DATA:    shreg  <= {vote, shreg[SIZE_DATA-1:1]};
            PARITY:  perr_q <= (vote != par_exp);
            STOP:    if (!vote) ferr_q <= 1'b1;
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state == DATA) bit_cnt  <= bit_cnt + BIT_W'(1);
          if (state == STOP) stop_idx <= 1'b1;
        end
      end
    end
  end

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [SIZE_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  full_q, pop, wr_ok, ovr_set;
  logic [WORD_W-1:0]     head;

  assign pop     = i_rd_en && (count != '0);
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign wr_ok   = wr_valid && (!full_q || pop);
  assign ovr_set = wr_valid && full_q && !pop;

  always_comb begin
    count_next = count;
    case ({wr_ok, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: storage is left unreset; the count gates every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + SIZE_DEPTH'(1);
      if (pop)   rd_ptr <= rd_ptr + SIZE_DEPTH'(1);
      count  <= count_next;
      full_q <= (count_next == CNT_W'(DEPTH));
      if (ovr_set)        o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign o_rx_valid   = (count != '0);
  assign o_rx_data    = o_rx_valid ? head[SIZE_DATA-1:0] : '0;
  assign o_rx_perr    = o_rx_valid & head[SIZE_DATA];
  assign o_rx_ferr    = o_rx_valid & head[SIZE_DATA+1];
  assign o_fifo_full  = full_q;
  assign o_fifo_count = count;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Bench for uart_rx_fifo_gen: a serial transmitter locked to the oversample tick,
// a directed vector table, corner-case sequences and random frames against a queue model.
module tb_uart_rx_fifo_gen;

  localparam int OS    = 16;
  localparam int MID   = 8;
  localparam int DEPTH = 16;

  logic       clk;
  logic       i_rst, i_stick, i_rx_en, i_parity_en, i_parity_odd, i_two_stop;
  logic       i_rx_data, i_rd_en, i_clr_err;
  logic [7:0] o_rx_data;
  logic       o_rx_perr, o_rx_ferr, o_rx_valid, o_fifo_full, o_overrun, o_busy;
  logic [4:0] o_fifo_count;

  uart_rx_fifo_gen #(
    .SIZE_DATA(8), .SIZE_DEPTH(4), .OVER_SAMPLE(OS), .MID_SAMPLE(MID)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stick(i_stick), .i_rx_en(i_rx_en),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
    .i_rx_data(i_rx_data), .i_rd_en(i_rd_en), .i_clr_err(i_clr_err),
    .o_rx_data(o_rx_data), .o_rx_perr(o_rx_perr), .o_rx_ferr(o_rx_ferr),
    .o_rx_valid(o_rx_valid), .o_fifo_full(o_fifo_full), .o_fifo_count(o_fifo_count),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par_en, odd, two, par_bit, stop1, stop2, glitch;
    int         at_write;   // 1: pulse i_rd_en, 2: pulse i_clr_err, in the FIFO write cycle
    int         abort;      // 1: reset, 2: drop i_rx_en, part-way through bit abort_bit
    int         abort_bit;
  } frame_t;

  typedef struct {
    frame_t     f;
    logic [9:0] exp;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] mq[$];
  logic       model_ovr = 1'b0;
  vec_t       vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversample tick: one cycle high in every four.
  initial begin
    i_stick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 i_stick = 1'b1;
      @(posedge clk);
      #1 i_stick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic frame_t mk(logic [7:0] d, logic pe, logic od, logic tw,
                                logic pb, logic s1, logic s2, logic gl);
    frame_t f;
    f.data = d; f.par_en = pe; f.odd = od; f.two = tw; f.par_bit = pb;
    f.stop1 = s1; f.stop2 = s2; f.glitch = gl;
    f.at_write = 0; f.abort = 0; f.abort_bit = 0;
    return f;
  endfunction

  function automatic vec_t mv(frame_t f, logic [9:0] e);
    vec_t v;
    v.f = f; v.exp = e;
    return v;
  endfunction

  // Reference: parity error when the received bit differs from the expected
  // parity, frame error when any checked stop bit is 0.
  function automatic logic [9:0] exp_word(frame_t f);
    logic perr, ferr;
    perr = f.par_en && (f.par_bit != ((^f.data) ^ f.odd));
    ferr = !f.stop1 || (f.two && !f.stop2);
    return {ferr, perr, f.data};
  endfunction

  function automatic void model_write(logic [9:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else model_ovr = 1'b1;
  endfunction

  task automatic wait_stick();
    do @(posedge clk); while (i_stick !== 1'b1);
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) wait_stick();
  endtask

  function automatic logic [9:0] dut_word();
    return {o_rx_ferr, o_rx_perr, o_rx_data};
  endfunction

  // Line value driven in tick slot s is what the receiver samples at its tick s.
  task automatic send_frame(input frame_t f);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.par_en) bits.push_back(f.par_bit);
    bits.push_back(f.stop1);
    if (f.two) bits.push_back(f.stop2);
    i_parity_en = f.par_en; i_parity_odd = f.odd; i_two_stop = f.two;
    for (int b = 0; b < bits.size(); b++) begin
      for (int s = 0; s < OS; s++) begin
        wait_stick();
        #1;
        if (b == 2 && s == 0) begin
          i_parity_en = ~i_parity_en; i_parity_odd = ~i_parity_odd; i_two_stop = ~i_two_stop;
        end
        if (f.abort != 0 && b == f.abort_bit && s == 4) begin
          i_rx_data = 1'b1;
          if (f.abort == 1) begin
            i_rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_busy", o_busy, 0);
            check("rst_valid", o_rx_valid, 0);
            check("rst_count", o_fifo_count, 0);
            check("rst_full", o_fifo_full, 0);
            check("rst_overrun", o_overrun, 0);
            check("rst_word", dut_word(), 0);
            @(posedge clk);
            #1 i_rst = 1'b0;
          end else begin
            i_rx_en = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("rxen_busy", o_busy, 0);
            @(posedge clk);
            #1 i_rx_en = 1'b1;
          end
          return;
        end
        i_rx_data = (f.glitch && b == 1 && s == MID) ? ~bits[b] : bits[b];
        if (b == bits.size() - 1 && s == MID + 2 && f.at_write != 0) begin
          if (f.at_write == 1) i_rd_en = 1'b1;
          else                 i_clr_err = 1'b1;
          @(posedge clk);
          #1;
          i_rd_en = 1'b0;
          i_clr_err = 1'b0;
        end
      end
    end
    wait_stick();
    #1 i_rx_data = 1'b1;
    idle_ticks(2);
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    e = mq.pop_front();
    @(negedge clk);
    check({name, "_valid"}, o_rx_valid, 1);
    check({name, "_word"}, dut_word(), e);
    @(posedge clk);
    #1 i_rd_en = 1'b1;
    @(posedge clk);
    #1 i_rd_en = 1'b0;
    @(negedge clk);
    check({name, "_count"}, o_fifo_count, mq.size());
  endtask

  initial begin
    frame_t f;
    vecs.push_back(mv(mk(8'h55, 0, 0, 0, 0, 1, 1, 0), 10'h055));
    vecs.push_back(mv(mk(8'hA3, 0, 0, 0, 0, 1, 1, 0), 10'h0A3));
    vecs.push_back(mv(mk(8'hA3, 1, 0, 0, 1, 1, 1, 0), 10'h1A3));
    vecs.push_back(mv(mk(8'hA3, 1, 1, 0, 1, 1, 1, 0), 10'h0A3));
    vecs.push_back(mv(mk(8'hA3, 1, 0, 0, 0, 1, 1, 0), 10'h0A3));
    vecs.push_back(mv(mk(8'h3C, 0, 0, 1, 0, 1, 0, 0), 10'h23C));
    vecs.push_back(mv(mk(8'h3C, 0, 0, 0, 0, 0, 1, 0), 10'h23C));
    vecs.push_back(mv(mk(8'h54, 0, 0, 0, 0, 1, 1, 1), 10'h054));
    vecs.push_back(mv(mk(8'h00, 0, 0, 1, 0, 1, 1, 0), 10'h000));
    vecs.push_back(mv(mk(8'hFF, 1, 1, 1, 1, 1, 1, 0), 10'h0FF));
    vecs.push_back(mv(mk(8'h81, 1, 0, 1, 1, 0, 1, 0), 10'h381));

    i_rst = 1'b1; i_rx_en = 1'b1; i_rx_data = 1'b1; i_rd_en = 1'b0; i_clr_err = 1'b0;
    i_parity_en = 1'b0; i_parity_odd = 1'b0; i_two_stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_valid", o_rx_valid, 0);
    check("reset_count", o_fifo_count, 0);
    check("reset_full", o_fifo_full, 0);
    check("reset_overrun", o_overrun, 0);
    check("reset_word", dut_word(), 0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    idle_ticks(2);

    // Directed vector table: one frame, inspect head, pop.
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].f);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), o_rx_valid, 1);
      check($sformatf("vec%0d_word", i), dut_word(), vecs[i].exp);
      @(posedge clk);
      #1 i_rd_en = 1'b1;
      @(posedge clk);
      #1 i_rd_en = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), o_fifo_count, 0);
    end

    // Two frames queued, then drained in order.
    f = mk(8'h55, 0, 0, 0, 0, 1, 1, 0); model_write(exp_word(f)); send_frame(f);
    f = mk(8'hA3, 0, 0, 0, 0, 1, 1, 0); model_write(exp_word(f)); send_frame(f);
    @(negedge clk);
    check("two_count", o_fifo_count, 2);
    pop_check("two_a");
    check("two_valid_mid", o_rx_valid, 1);
    pop_check("two_b");
    check("two_valid_end", o_rx_valid, 0);
    check("empty_word", dut_word(), 0);

    // False start: line low for only four ticks.
    for (int s = 0; s < 4; s++) begin
      wait_stick();
      #1 i_rx_data = 1'b0;
    end
    wait_stick();
    #1 i_rx_data = 1'b1;
    @(negedge clk);
    check("false_start_busy", o_busy, 1);
    idle_ticks(12);
    @(negedge clk);
    check("false_start_idle", o_busy, 0);
    check("false_start_count", o_fifo_count, 0);

    // Pop while empty is ignored.
    @(posedge clk);
    #1 i_rd_en = 1'b1;
    @(posedge clk);
    #1 i_rd_en = 1'b0;
    @(negedge clk);
    check("pop_empty_count", o_fifo_count, 0);

    // Write and pop together while empty: the write lands.
    f = mk(8'h96, 0, 0, 0, 0, 1, 1, 0); f.at_write = 1;
    model_write(exp_word(f));
    send_frame(f);
    @(negedge clk);
    check("wr_pop_empty_count", o_fifo_count, 1);
    pop_check("wr_pop_empty");

    // Fill beyond capacity.
    for (int i = 0; i < DEPTH + 1; i++) begin
      f = mk(8'($urandom), 0, 0, 0, 0, 1, 1, 0);
      model_write(exp_word(f));
      send_frame(f);
    end
    @(negedge clk);
    check("fill_count", o_fifo_count, DEPTH);
    check("fill_full", o_fifo_full, 1);
    check("fill_overrun", o_overrun, model_ovr);
    @(posedge clk);
    #1 i_clr_err = 1'b1;
    @(posedge clk);
    #1 i_clr_err = 1'b0;
    model_ovr = 1'b0;
    @(negedge clk);
    check("clr_overrun", o_overrun, 0);

    // Write and pop together while full.
    f = mk(8'hC7, 1, 1, 0, 0, 1, 1, 0); f.at_write = 1;
    void'(mq.pop_front());
    mq.push_back(exp_word(f));
    send_frame(f);
    @(negedge clk);
    check("full_wr_pop_count", o_fifo_count, DEPTH);
    check("full_wr_pop_full", o_fifo_full, 1);
    check("full_wr_pop_ovr", o_overrun, 0);

    // Clear and new overrun in the same cycle: the set wins.
    f = mk(8'h5A, 0, 0, 0, 0, 1, 1, 0); f.at_write = 2;
    model_write(exp_word(f));
    send_frame(f);
    @(negedge clk);
    check("clr_vs_set_ovr", o_overrun, model_ovr);
    check("clr_vs_set_count", o_fifo_count, DEPTH);

    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
    check("drain_full", o_fifo_full, 0);
    check("drain_valid", o_rx_valid, 0);

    // Pointers have wrapped; keep going.
    for (int i = 0; i < 3; i++) begin
      f = mk(8'($urandom), 1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1, 1, 0);
      model_write(exp_word(f));
      send_frame(f);
    end
    for (int i = 0; i < 3; i++) pop_check($sformatf("wrap%0d", i));

    // Reset in the middle of DATA flushes everything; next frame is clean.
    f = mk(8'h11, 0, 0, 0, 0, 1, 1, 0); model_write(exp_word(f)); send_frame(f);
    f = mk(8'hE7, 0, 0, 0, 0, 1, 1, 0); f.abort = 1; f.abort_bit = 4;
    send_frame(f);
    mq.delete();
    model_ovr = 1'b0;
    idle_ticks(20);
    @(negedge clk);
    check("post_rst_count", o_fifo_count, 0);
    f = mk(8'h3C, 0, 0, 0, 0, 1, 1, 0); model_write(exp_word(f)); send_frame(f);
    pop_check("post_rst_frame");

    // Dropping i_rx_en mid-frame discards the frame but keeps stored words.
    f = mk(8'h22, 0, 0, 0, 0, 1, 1, 0); model_write(exp_word(f)); send_frame(f);
    f = mk(8'hBD, 0, 0, 0, 0, 1, 1, 0); f.abort = 2; f.abort_bit = 6;
    send_frame(f);
    idle_ticks(20);
    @(negedge clk);
    check("rxen_count", o_fifo_count, mq.size());
    pop_check("rxen_kept");

    // Random frames and pops against the queue model.
    for (int i = 0; i < 16; i++) begin
      f = mk(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));
      model_write(exp_word(f));
      send_frame(f);
      @(negedge clk);
      check($sformatf("rand%0d_count", i), o_fifo_count, mq.size());
      check($sformatf("rand%0d_ovr", i), o_overrun, model_ovr);
      for (int j = 0, n = $urandom_range(0, 2); j < n; j++)
        if (mq.size() > 0) pop_check($sformatf("rand%0d_pop", i));
    end
    while (mq.size() > 0) pop_check("rand_drain");
    check("final_valid", o_rx_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
